dtw_result_unloader: RTL and testbench



---
 rtl/dtw_result_unloader.sv | 226 ++++++++++++++++++++++
 tb/tb_dtw_result_unloader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dtw_result_unloader.sv
// Streams one pass of DTW result words from the shared SRAM to a valid/ready sink.
// Optional feature: define DTW_UNLOAD_CHECKSUM_EN to add a running checksum output.
module dtw_result_unloader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int BASE_ADDR  = 20,
    parameter int NUM_WORDS  = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bus_gnt,
    output logic              bus_req,
    output logic              CS,
    output logic              WR,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef DTW_UNLOAD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int CNT_W  = $clog2(NUM_WORDS + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic                cs_q, cs_d;
    logic                inflight_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [DATA_W-1:0]   head_s;
    logic                bus_req_q, bus_req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_s, issue_s, last_issue_s, push_s, pop_s;
    logic [FCNT_W:0]     credit_s;

    // A word is outstanding both while CS is low and during the following data cycle.
    assign start_s      = (state_q == S_IDLE) && start;
    assign push_s       = inflight_q;
    assign pop_s        = out_valid_q && out_ready;
    assign credit_s     = {1'b0, count_q} + {{FCNT_W{1'b0}}, ~cs_q} + {{FCNT_W{1'b0}}, inflight_q};
    assign issue_s      = ((state_q == S_REQ) || (state_q == S_READ)) && bus_gnt
                          && (credit_s < (FCNT_W + 1)'(FIFO_DEPTH));
    assign last_issue_s = issue_s && (rd_idx_q == LAST_IDX);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; the grant cycle in REQ already issues the first read
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_REQ;
                else       state_d = S_IDLE;
            end
            S_REQ: begin
                if (last_issue_s) state_d = S_DRAIN;
                else if (bus_gnt) state_d = S_READ;
                else              state_d = S_REQ;
            end
            S_READ: begin
                if (last_issue_s) state_d = S_DRAIN;
                else              state_d = S_READ;
            end
            S_DRAIN: begin
                if ((count_d == '0) && cs_q) state_d = S_FIN;
                else                         state_d = S_DRAIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output and datapath next-state logic
    always_comb begin
        if (start_s) begin
            rd_idx_d = '0;
            acc_d    = '0;
        end else begin
            if (issue_s) rd_idx_d = rd_idx_q + CNT_W'(1);
            else         rd_idx_d = rd_idx_q;
            if (pop_s)   acc_d = acc_q + CNT_W'(1);
            else         acc_d = acc_q;
        end

        if (issue_s) begin
            cs_d   = 1'b0;
            addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx_q);
        end else begin
            cs_d   = 1'b1;
            addr_d = addr_q;
        end

        if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        else        wr_ptr_d = wr_ptr_q;
        if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        else        rd_ptr_d = rd_ptr_q;
        count_d = count_q + FCNT_W'(push_s) - FCNT_W'(pop_s);

        // When the FIFO drains to nothing this cycle, the incoming word becomes the head.
        if ((count_q == '0) || ((count_q == FCNT_W'(1)) && pop_s)) head_s = DATA;
        else                                                        head_s = mem_q[rd_ptr_d];

        out_valid_d = (count_d != '0);
        if (out_valid_d) begin
            out_data_d = head_s;
            out_last_d = (acc_d == LAST_IDX);
        end else begin
            out_data_d = '0;
            out_last_d = 1'b0;
        end

        bus_req_d = (state_d == S_REQ) || (state_d == S_READ);
        busy_d    = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_DRAIN);
        done_d    = (state_d == S_FIN);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q    <= '0;
            acc_q       <= '0;
            cs_q        <= 1'b1;
            inflight_q  <= 1'b0;
            addr_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_idx_q    <= rd_idx_d;
            acc_q       <= acc_d;
            cs_q        <= cs_d;
            inflight_q  <= ~cs_q;
            addr_q      <= addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            bus_req_q   <= bus_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // FIFO storage captures SRAM data in the cycle after CS was low
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= DATA;
        end
    end

`ifdef DTW_UNLOAD_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Checksum next value: sum of accepted words, restarted by an accepted start
    always_comb begin
        if (start_s)    checksum_d = '0;
        else if (pop_s) checksum_d = checksum_q + out_data_q;
        else            checksum_d = checksum_q;
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign bus_req   = bus_req_q;
    assign CS        = cs_q;
    assign WR        = 1'b0;
    assign ADDR      = addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dtw_result_unloader.sv
// Randomized self-checking bench: the expected stream is simply the SRAM result window in order.
module tb_dtw_result_unloader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int BASE   = 20;
    localparam int NW     = 40;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst, start, bus_gnt, bus_req, cs, wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              out_valid, out_ready, out_last, busy, done;
    logic [DATA_W-1:0] out_data;
`ifdef DTW_UNLOAD_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    dtw_result_unloader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE),
        .NUM_WORDS(NW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus_gnt(bus_gnt), .bus_req(bus_req),
        .CS(cs), .WR(wr), .ADDR(addr), .DATA(data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
`ifdef DTW_UNLOAD_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // SRAM model: registered read while CS is low
    logic [DATA_W-1:0] sram [0:1023];
    always @(posedge clk) begin
        if (!cs) data <= sram[addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          n, mode, rd_exp, acc, done_cnt, done_at, first_valid, rst_obs;
    logic        prev_gnt;
    logic [31:0] csum;

    // One cycle: drive inputs for the coming edge, then check what the DUT shows now.
    task automatic step();
        @(negedge clk);
        start = (n == -1) || (mode == 5 && (n == 10 || n == 25));
        case (mode)
            2:       bus_gnt = !(n <= 4);
            3:       bus_gnt = !(n >= 15 && n <= 17);
            4:       bus_gnt = ($urandom_range(0, 3) != 0);
            default: bus_gnt = 1'b1;
        endcase
        case (mode)
            1:       out_ready = !(n >= 3 && n <= 12);
            4:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b1;
        endcase
        if (mode == 6 && rst_obs < 0 && acc == 15) begin
            rst     = 1'b1;
            rst_obs = n;
        end else begin
            rst = 1'b0;
        end

        if (mode == 6 && rst_obs >= 0 && n == rst_obs + 1) begin
            check_eq("rst_cs", cs, 1);
            check_eq("rst_valid", out_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_bus_req", bus_req, 0);
            check_eq("rst_addr", addr, 0);
            check_eq("rst_last", out_last, 0);
`ifdef DTW_UNLOAD_CHECKSUM_EN
            check_eq("rst_checksum", checksum, 0);
`endif
        end
        if (mode == 2 && n >= 0 && n <= 5) begin
            check_eq("nognt_cs", cs, 1);
            check_eq("nognt_bus_req", bus_req, 1);
        end
        if (!cs) begin
            check_eq("rd_addr", addr, BASE + rd_exp);
            check_eq("rd_granted", prev_gnt, 1);
            rd_exp++;
        end
        check_eq("wr_low", wr, 0);
        if (mode == 1 && n == 12) begin
            check_eq("bp_reads", rd_exp, 4);
            check_eq("bp_cs_high", cs, 1);
        end
        if (out_valid && first_valid < 0) first_valid = n;
        if (out_valid && out_ready && !rst) begin
            if (acc < NW) begin
                check_eq("out_data", out_data, sram[BASE + acc]);
                check_eq("out_last", out_last, acc == NW - 1);
            end else begin
                check_eq("extra_word", acc, NW - 1);
            end
            csum = csum + out_data;
            acc++;
        end
        if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
`ifdef DTW_UNLOAD_CHECKSUM_EN
            check_eq("checksum", checksum, csum);
`endif
        end
        prev_gnt = bus_gnt;
        n++;
    endtask

    task automatic run_pass(input int m);
        bit fin;
        mode = m; n = -1; rd_exp = 0; acc = 0; done_cnt = 0; done_at = -1;
        first_valid = -1; rst_obs = -1; csum = 32'd0; prev_gnt = bus_gnt;
        fin = 1'b0;
        while (!fin && n < 1500) begin
            step();
            if (mode == 6) fin = (rst_obs >= 0 && n > rst_obs + 4);
            else           fin = (done_at >= 0 && n > done_at + 4);
        end
        if (mode == 6) begin
            check_eq("rst_no_done", done_cnt, 0);
            check_eq("rst_words", acc, 15);
        end else begin
            check_eq("done_seen", done_at >= 0, 1);
            check_eq("done_pulses", done_cnt, 1);
            check_eq("words", acc, NW);
            check_eq("reads", rd_exp, NW);
            check_eq("busy_after", busy, 0);
        end
        if (m == 0) begin
            check_eq("first_valid_lat", first_valid, 3);
            check_eq("done_lat", done_at, 43);
        end
        if (m == 1) check_eq("bp_first_valid", first_valid, 3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bus_gnt = 1'b0; out_ready = 1'b0;
        mode = 0; n = 0; acc = 0; rst_obs = -1;
        for (int a = 0; a < 1024; a++) sram[a] = $urandom;
        for (int i = 0; i < NW; i++) sram[BASE + i] = 32'h0000_1000 + i;

        repeat (3) @(negedge clk);
        check_eq("reset_cs", cs, 1);
        check_eq("reset_wr", wr, 0);
        check_eq("reset_addr", addr, 0);
        check_eq("reset_bus_req", bus_req, 0);
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_data", out_data, 0);
        check_eq("reset_last", out_last, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        run_pass(0);  // basic pass
        run_pass(1);  // backpressure
        run_pass(2);  // grant withheld at start
        run_pass(3);  // grant dropped mid-pass
        run_pass(5);  // stray starts while busy
        run_pass(6);  // reset after 15 words
        run_pass(0);  // clean restart
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NW; i++) sram[BASE + i] = $urandom;
            run_pass(4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
